pkt_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares the single `xge_mac` transmit packet interface (`pkt_tx_*`) between `NUM_SRC` independent packet sources. It sits between the UVM sequencer-driven source agents (or future on-chip generators) and the MAC `pkt_tx` port, in the `clk_156m25` domain. It grants one source per packet, holds the grant from SOP to EOP, honours `pkt_tx_full` backpressure, and keeps per-source protocol-error flags and a forwarded-packet counter.

---
 rtl/xge_tb_pkg.sv | 34 +++
 rtl/pkt_tx_arbiter_rr_pick.sv | 37 +++
 rtl/pkt_tx_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/xge_tb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : xge_tb_pkg
// Description : Shared types and constants for the 10G packet TX path:
//               the MAC lane word, lane widths and the arbiter FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package xge_tb_pkg;

   localparam int C_LANE_W = 64;   // MAC data lane width
   localparam int C_MOD_W  = 3;    // byte-valid modulo width on EOP

   // One word of the pkt_tx interface
   typedef struct packed {
      logic [C_LANE_W-1:0] data;
      logic                sop;
      logic                eop;
      logic [C_MOD_W-1:0]  mod;
   } pkt_word_t;

   // Packet-granular arbiter states
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } arb_state_e;

   // Width of an index into n sources (at least 1 bit)
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : xge_tb_pkg
`default_nettype wire

// File: rtl/pkt_tx_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns a one-hot vector
//               selecting the first set candidate scanning upward from
//               last+1, wrapping modulo NUM_SRC.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int LW      = 2
) (
   input  logic [NUM_SRC-1:0] cand,
   input  logic [LW-1:0]      last,
   output logic [NUM_SRC-1:0] pick
);

   int   w_idx;
   logic w_found;

   // Scan candidates starting just after the previous winner
   always_comb begin
      pick    = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         w_idx = (int'(last) + k) % NUM_SRC;
         if (!w_found && cand[w_idx]) begin
            pick[w_idx] = 1'b1;
            w_found     = 1'b1;
         end
      end
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/pkt_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pkt_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing the xge_mac
//               pkt_tx interface between NUM_SRC sources. Holds a grant from
//               SOP to EOP, honours pkt_tx_full, drops orphan words and keeps
//               sticky protocol-error flags plus a forwarded-packet counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_arbiter
   import xge_tb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DW      = C_LANE_W
) (
   input  logic                  clk_156m25,
   input  logic                  reset_156m25_n,
   input  logic [NUM_SRC*DW-1:0] src_data,
   input  logic [NUM_SRC-1:0]    src_val,
   input  logic [NUM_SRC-1:0]    src_sop,
   input  logic [NUM_SRC-1:0]    src_eop,
   input  logic [NUM_SRC*3-1:0]  src_mod,
   input  logic [NUM_SRC-1:0]    src_en,
   output logic [NUM_SRC-1:0]    src_rdy,
   output logic [NUM_SRC-1:0]    grant,
   output logic                  busy,
   output logic [63:0]           pkt_tx_data,
   output logic                  pkt_tx_val,
   output logic                  pkt_tx_sop,
   output logic                  pkt_tx_eop,
   output logic [2:0]            pkt_tx_mod,
   input  logic                  pkt_tx_full,
   input  logic                  err_clr,
   output logic [NUM_SRC-1:0]    err_orphan,
   output logic [NUM_SRC-1:0]    err_sop,
   output logic [31:0]           pkt_cnt
);

   localparam int LW = idx_w(NUM_SRC);

   arb_state_e           r_state, w_state_nxt;
   logic [NUM_SRC-1:0]   r_grant, w_grant_nxt;
   logic [LW-1:0]        r_last,  w_last_nxt;
   logic                 r_started, w_started_nxt;   // first word of grant already moved
   logic [NUM_SRC-1:0]   w_cand, w_pick, w_orphan, w_sop_set;
   logic [LW-1:0]        w_gidx;
   pkt_word_t            w_sel;
   logic                 w_sel_val, w_xfer;
   pkt_word_t            r_out;
   logic                 r_out_val;
   logic [NUM_SRC-1:0]   r_err_orphan, r_err_sop;
   logic [31:0]          r_pkt_cnt;

   assign w_cand = src_val & src_sop & src_en;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .LW      (LW)
   ) u_rr_pick (
      .cand (w_cand),
      .last (r_last),
      .pick (w_pick)
   );

   // Mux the granted source's word and encode the grant as an index
   always_comb begin
      w_sel     = '0;
      w_sel_val = 1'b0;
      w_gidx    = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_grant[i]) begin
            w_sel.data = src_data[i*DW +: DW];
            w_sel.sop  = src_sop[i];
            w_sel.eop  = src_eop[i];
            w_sel.mod  = src_mod[i*3 +: 3];
            w_sel_val  = src_val[i];
            w_gidx     = LW'(i);
         end
      end
   end

   assign w_xfer    = (r_state == ST_PKT) && w_sel_val && !pkt_tx_full;
   assign w_orphan  = (r_state == ST_IDLE) ? (src_val & ~src_sop) : '0;
   assign w_sop_set = (w_xfer && w_sel.sop && r_started) ? r_grant : '0;

   // Ready: granted source in PKT, orphan sinks in IDLE, nothing while in reset
   assign src_rdy = !reset_156m25_n ? '0 :
                    (r_state == ST_PKT) ? (r_grant & {NUM_SRC{!pkt_tx_full}}) :
                    w_orphan;

   // Next-state logic: arbitrate in IDLE, hold the grant until the EOP transfer
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_last_nxt    = r_last;
      w_started_nxt = r_started;
      case (r_state)
         ST_IDLE: begin
            if (|w_cand) begin
               w_state_nxt   = ST_PKT;
               w_grant_nxt   = w_pick;
               w_started_nxt = 1'b0;
            end
         end
         ST_PKT: begin
            if (w_xfer) begin
               w_started_nxt = 1'b1;
               if (w_sel.eop) begin
                  w_state_nxt   = ST_IDLE;
                  w_grant_nxt   = '0;
                  w_last_nxt    = w_gidx;
                  w_started_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_grant_nxt   = '0;
            w_started_nxt = 1'b0;
         end
      endcase
   end

   // State, grant and round-robin pointer registers
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_last    <= LW'(NUM_SRC - 1);
         r_started <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_last    <= w_last_nxt;
         r_started <= w_started_nxt;
      end
   end

   // Registered MAC output stage; all fields forced to zero when not valid
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_out     <= '0;
         r_out_val <= 1'b0;
      end else begin
         r_out_val  <= w_xfer;
         r_out.data <= w_xfer ? w_sel.data : '0;
         r_out.sop  <= w_xfer & w_sel.sop;
         r_out.eop  <= w_xfer & w_sel.eop;
         r_out.mod  <= (w_xfer && w_sel.eop) ? w_sel.mod : 3'd0;
      end
   end

   // Sticky error flags (set beats clear) and forwarded-packet counter
   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         r_err_orphan <= '0;
         r_err_sop    <= '0;
         r_pkt_cnt    <= '0;
      end else begin
         r_err_orphan <= (err_clr ? '0 : r_err_orphan) | w_orphan;
         r_err_sop    <= (err_clr ? '0 : r_err_sop) | w_sop_set;
         if (w_xfer && w_sel.eop) begin
            r_pkt_cnt <= r_pkt_cnt + 32'd1;
         end
      end
   end

   assign grant       = r_grant;
   assign busy        = (r_state == ST_PKT);
   assign pkt_tx_data = r_out.data;
   assign pkt_tx_val  = r_out_val;
   assign pkt_tx_sop  = r_out.sop;
   assign pkt_tx_eop  = r_out.eop;
   assign pkt_tx_mod  = r_out.mod;
   assign err_orphan  = r_err_orphan;
   assign err_sop     = r_err_sop;
   assign pkt_cnt     = r_pkt_cnt;

endmodule : pkt_tx_arbiter
`default_nettype wire
